// File: rtl/id_operand_stage_if.sv
// Bus bundle for the decode-side operand stage.
// Carries the upstream decode handshake, the register file read port, the
// observed write-back port, the EX/MEM and MEM/WB result buses, and the
// operand outputs toward EX.
//   slave  : the operand stage itself (consumes decode/bus inputs, drives
//            read addresses, stall and operands)
//   master : the surrounding pipeline / testbench
// Optional OPFWD_STATS_EN adds the stat_stalls / stat_fwds counters.
interface id_operand_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              flush;
   logic              in_valid;
   logic [ADDR_W-1:0] in_rs;
   logic [ADDR_W-1:0] in_rt;
   logic [ADDR_W-1:0] in_rd;
   logic              stall_o;
   logic [ADDR_W-1:0] rf_raddr1;
   logic [ADDR_W-1:0] rf_raddr2;
   logic [DATA_W-1:0] rf_rdata1;
   logic [DATA_W-1:0] rf_rdata2;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              exm_we;
   logic [ADDR_W-1:0] exm_rd;
   logic [DATA_W-1:0] exm_data;
   logic              exm_load;
   logic              mwb_we;
   logic [ADDR_W-1:0] mwb_rd;
   logic [DATA_W-1:0] mwb_data;
   logic              out_valid;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [ADDR_W-1:0] out_rd;
`ifdef OPFWD_STATS_EN
   logic [31:0]       stat_stalls;
   logic [31:0]       stat_fwds;
`endif

   modport slave (
`ifdef OPFWD_STATS_EN
      output stat_stalls, stat_fwds,
`endif
      input  flush, in_valid, in_rs, in_rt, in_rd,
      input  rf_rdata1, rf_rdata2,
      input  wb_we, wb_rd, wb_data,
      input  exm_we, exm_rd, exm_data, exm_load,
      input  mwb_we, mwb_rd, mwb_data,
      output stall_o, rf_raddr1, rf_raddr2,
      output out_valid, op_a, op_b, out_rd
   );

   modport master (
`ifdef OPFWD_STATS_EN
      input  stat_stalls, stat_fwds,
`endif
      output flush, in_valid, in_rs, in_rt, in_rd,
      output rf_rdata1, rf_rdata2,
      output wb_we, wb_rd, wb_data,
      output exm_we, exm_rd, exm_data, exm_load,
      output mwb_we, mwb_rd, mwb_data,
      input  stall_o, rf_raddr1, rf_raddr2,
      input  out_valid, op_a, op_b, out_rd
   );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-side operand stage sitting right after a synchronous-read register
// file. Stage A holds the decoded instruction while its register file read
// is in flight; one cycle later the returned data is merged with the
// EX/MEM, MEM/WB and last-write bypass paths and registered toward EX.
// Load-use hazards against EX/MEM stall the upstream and insert bubbles.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset (beats flush)
//   bus  - id_operand_stage_if.slave: decode input, rf read port, result
//          buses, operands out (see interface file)
// Configuration macro: OPFWD_STATS_EN adds stall / forward counters.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic               clk,
   input logic               rst,
   id_operand_stage_if.slave bus
);
   typedef enum logic {RUN, STALL} state_t;
   typedef enum logic [2:0] {SRC_ZERO, SRC_EXM, SRC_MWB, SRC_BYP, SRC_RF} src_t;

   state_t            state_q;
   state_t            state_d;
   logic              a_valid;
   logic [ADDR_W-1:0] a_rs;
   logic [ADDR_W-1:0] a_rt;
   logic [ADDR_W-1:0] a_rd;
   logic              byp_we;
   logic [ADDR_W-1:0] byp_rd;
   logic [DATA_W-1:0] byp_data;
   logic              hazard;
   logic              stall;
   logic              issue;
   logic [ADDR_W-1:0] src_idx   [2];
   logic [DATA_W-1:0] src_rdata [2];
   src_t              src_sel   [2];
   logic [DATA_W-1:0] sel_data  [2];
   logic              out_valid_q;
   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;
   logic [ADDR_W-1:0] out_rd_q;

   // A load still in EX/MEM cannot supply its data yet; stage A must wait
   // until it reaches MEM/WB. Register 0 never creates a dependency.
   assign hazard = a_valid && bus.exm_we && bus.exm_load && (bus.exm_rd != '0) &&
                   ((bus.exm_rd == a_rs) || (bus.exm_rd == a_rt));

   // Stall state register; rst always returns to RUN.
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next state and stall request. Flush overrides a pending hazard since
   // the stalled instruction is being discarded anyway.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         RUN: begin
            if (hazard) begin
               state_d = STALL;
               stall   = 1'b1;
            end
         end
         STALL: begin
            if (hazard) stall   = 1'b1;
            else        state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (bus.flush) begin
         state_d = RUN;
         stall   = 1'b0;
      end
   end

   assign issue       = a_valid && !stall && !bus.flush;
   assign bus.stall_o = stall;

   // While stalled, re-read stage A sources so the data returned next cycle
   // still belongs to the held instruction.
   assign bus.rf_raddr1 = stall ? a_rs : bus.in_rs;
   assign bus.rf_raddr2 = stall ? a_rt : bus.in_rt;

   // The register file returns pre-write data when a write and read hit the
   // same index in one cycle; remembering last cycle's write covers that.
   always_ff @(posedge clk) begin
      byp_we   <= bus.wb_we;
      byp_rd   <= bus.wb_rd;
      byp_data <= bus.wb_data;
   end

   assign src_idx[0]   = a_rs;
   assign src_idx[1]   = a_rt;
   assign src_rdata[0] = bus.rf_rdata1;
   assign src_rdata[1] = bus.rf_rdata2;

   // Pick the freshest source for each operand, youngest producer first.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_sel[s] = SRC_RF;
         if (src_idx[s] == '0)
            src_sel[s] = SRC_ZERO;
         else if (bus.exm_we && !bus.exm_load && (bus.exm_rd == src_idx[s]))
            src_sel[s] = SRC_EXM;
         else if (bus.mwb_we && (bus.mwb_rd == src_idx[s]))
            src_sel[s] = SRC_MWB;
         else if (byp_we && (byp_rd == src_idx[s]))
            src_sel[s] = SRC_BYP;
         case (src_sel[s])
            SRC_ZERO: sel_data[s] = '0;
            SRC_EXM:  sel_data[s] = bus.exm_data;
            SRC_MWB:  sel_data[s] = bus.mwb_data;
            SRC_BYP:  sel_data[s] = byp_data;
            default:  sel_data[s] = src_rdata[s];
         endcase
      end
   end

   // Stage A capture and operand issue. Stage A only advances when the
   // upstream is not being held; operands hold their last value on bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid     <= 1'b0;
         a_rs        <= '0;
         a_rt        <= '0;
         a_rd        <= '0;
         out_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         out_rd_q    <= '0;
      end else if (bus.flush) begin
         a_valid     <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (stall) begin
         out_valid_q <= 1'b0;
      end else begin
         a_valid     <= bus.in_valid;
         a_rs        <= bus.in_rs;
         a_rt        <= bus.in_rt;
         a_rd        <= bus.in_rd;
         out_valid_q <= a_valid;
         if (a_valid) begin
            op_a_q   <= sel_data[0];
            op_b_q   <= sel_data[1];
            out_rd_q <= a_rd;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.out_rd    = out_rd_q;

`ifdef OPFWD_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] fwd_cnt;
   logic [1:0]  fwd_now;

   assign fwd_now = {1'b0, (src_sel[0] inside {SRC_EXM, SRC_MWB, SRC_BYP})} +
                    {1'b0, (src_sel[1] inside {SRC_EXM, SRC_MWB, SRC_BYP})};

   // Counters wrap naturally; flush does not clear them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall) stall_cnt <= stall_cnt + 32'd1;
         if (issue) fwd_cnt   <= fwd_cnt + {30'd0, fwd_now};
      end
   end

   assign bus.stat_stalls = stall_cnt;
   assign bus.stat_fwds   = fwd_cnt;
`else
   logic unused_issue;
   assign unused_issue = issue;
`endif
endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model that treats the register file as an array.
module tb_id_operand_stage;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   id_operand_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   id_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: synchronous read returning pre-write data.
   logic [31:0] mem [32];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] <= $urandom;
      mem[1] <= 32'd5;
      mem[2] <= 32'd7;
      mem[3] <= 32'd0;
      bus.rf_rdata1 <= '0;
      bus.rf_rdata2 <= '0;
   end
   always @(posedge clk) begin
      bus.rf_rdata1 <= mem[bus.rf_raddr1];
      bus.rf_rdata2 <= mem[bus.rf_raddr2];
      if (bus.wb_we) mem[bus.wb_rd] <= bus.wb_data;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: the pending instruction and the operands EX should see.
   logic        armed = 1'b0;
   logic        m_a_valid = 1'b0;
   logic [4:0]  m_a_rs = '0, m_a_rt = '0, m_a_rd = '0;
   logic        m_out_valid = 1'b0;
   logic [31:0] m_op_a = '0, m_op_b = '0;
   logic [4:0]  m_out_rd = '0;
   logic        m_stall_prev = 1'b0;
   logic        m_prev_wb_we = 1'b0;
   logic [4:0]  m_prev_wb_rd = '0;
   logic [31:0] m_stalls = '0, m_fwds = '0;
   logic        exp_stall;

   // Architectural value of a register as seen by EX right now.
   function automatic logic [31:0] operandValue(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (bus.exm_we && !bus.exm_load && bus.exm_rd == idx) return bus.exm_data;
      if (bus.mwb_we && bus.mwb_rd == idx) return bus.mwb_data;
      return mem[idx];
   endfunction

   function automatic logic [31:0] isForwarded(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if ((bus.exm_we && !bus.exm_load && bus.exm_rd == idx) ||
          (bus.mwb_we && bus.mwb_rd == idx) ||
          (m_prev_wb_we && m_prev_wb_rd == idx)) return 32'd1;
      return 32'd0;
   endfunction

   always @(negedge clk) begin
      exp_stall = m_a_valid && bus.exm_we && bus.exm_load && bus.exm_rd != 0 &&
                  (bus.exm_rd == m_a_rs || bus.exm_rd == m_a_rt) && !bus.flush;
      if (armed) begin
         checkOutput("stall_o", bus.stall_o, exp_stall);
         checkOutput("rf_raddr1", bus.rf_raddr1, exp_stall ? m_a_rs : bus.in_rs);
         checkOutput("rf_raddr2", bus.rf_raddr2, exp_stall ? m_a_rt : bus.in_rt);
         checkOutput("out_valid", bus.out_valid, m_out_valid);
         if (m_out_valid) begin
            checkOutput("op_a", bus.op_a, m_op_a);
            checkOutput("op_b", bus.op_b, m_op_b);
            checkOutput("out_rd", bus.out_rd, m_out_rd);
         end
`ifdef OPFWD_STATS_EN
         checkOutput("stat_stalls", bus.stat_stalls, m_stalls);
         checkOutput("stat_fwds", bus.stat_fwds, m_fwds);
`endif
      end
      if (rst) begin
         armed = 1'b1;
         m_a_valid = 1'b0; m_a_rs = '0; m_a_rt = '0; m_a_rd = '0;
         m_out_valid = 1'b0; m_op_a = '0; m_op_b = '0; m_out_rd = '0;
         m_stalls = '0; m_fwds = '0;
      end else if (bus.flush) begin
         m_a_valid = 1'b0;
         m_out_valid = 1'b0;
      end else if (exp_stall) begin
         m_out_valid = 1'b0;
         m_stalls = m_stalls + 1;
      end else begin
         if (m_a_valid) begin
            m_op_a = operandValue(m_a_rs);
            m_op_b = operandValue(m_a_rt);
            m_out_rd = m_a_rd;
            m_fwds = m_fwds + isForwarded(m_a_rs) + isForwarded(m_a_rt);
         end
         m_out_valid = m_a_valid;
         m_a_valid = bus.in_valid;
         m_a_rs = bus.in_rs; m_a_rt = bus.in_rt; m_a_rd = bus.in_rd;
      end
      m_prev_wb_we = bus.wb_we;
      m_prev_wb_rd = bus.wb_rd;
      m_stall_prev = exp_stall;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one decode slot with all result buses idle.
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      bus.in_valid = v; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.flush = 1'b0;
      bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.exm_we = 1'b0; bus.exm_rd = '0; bus.exm_data = '0; bus.exm_load = 1'b0;
      bus.mwb_we = 1'b0; bus.mwb_rd = '0; bus.mwb_data = '0;
   endtask

   task automatic resetPulse();
      tick();
      applyStimulus(0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic randomCycle();
      if (!m_stall_prev) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_rs = 5'($urandom_range(0, 7));
         bus.in_rt = 5'($urandom_range(0, 7));
         bus.in_rd = 5'($urandom_range(0, 31));
      end
      bus.wb_we = 1'($urandom_range(0, 1));
      bus.wb_rd = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.exm_we = 1'($urandom_range(0, 1));
      bus.exm_rd = 5'($urandom_range(0, 7));
      bus.exm_data = $urandom;
      bus.exm_load = ($urandom_range(0, 3) == 0);
      bus.mwb_we = 1'($urandom_range(0, 1));
      bus.mwb_rd = 5'($urandom_range(0, 7));
      bus.mwb_data = $urandom;
      bus.flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset op_a", bus.op_a, 0);
      checkOutput("reset op_b", bus.op_b, 0);
      checkOutput("reset out_rd", bus.out_rd, 0);
      checkOutput("reset stall_o", bus.stall_o, 0);

      // Plain read: rs=1 rt=2 returns 5/7 two cycles later.
      tick(); applyStimulus(1, 1, 2, 9);
      tick(); applyStimulus(0, 0, 0, 0);
      tick(); @(negedge clk);
      checkOutput("basic out_valid", bus.out_valid, 1);
      checkOutput("basic op_a", bus.op_a, 32'd5);
      checkOutput("basic op_b", bus.op_b, 32'd7);
      checkOutput("basic out_rd", bus.out_rd, 9);

      // Read-during-write: rf returns old 0, bypass supplies 0xAA.
      tick(); applyStimulus(1, 3, 0, 1);
      bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAA;
      tick(); applyStimulus(0, 0, 0, 0);
      tick(); @(negedge clk);
      checkOutput("rdw op_a", bus.op_a, 32'hAA);

      // EX/MEM beats MEM/WB for the same register.
      tick(); applyStimulus(1, 4, 0, 2);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd4; bus.exm_data = 32'h11;
      bus.mwb_we = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_data = 32'h22;
      tick(); applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("prio op_a", bus.op_a, 32'h11);

      resetPulse();

      // Load-use: one stall cycle, a bubble, then the MEM/WB value.
      tick(); applyStimulus(1, 5, 0, 3);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd5; bus.exm_load = 1'b1;
      @(negedge clk);
      checkOutput("loaduse stall_o", bus.stall_o, 1);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.mwb_we = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_data = 32'h33;
      @(negedge clk);
      checkOutput("loaduse stall clear", bus.stall_o, 0);
      checkOutput("loaduse bubble", bus.out_valid, 0);
      tick(); applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("loaduse out_valid", bus.out_valid, 1);
      checkOutput("loaduse op_a", bus.op_a, 32'h33);

      // Second forwarded operand from EX/MEM.
      tick(); applyStimulus(1, 6, 0, 4);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd6; bus.exm_data = 32'h44;
      tick(); applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("exm op_a", bus.op_a, 32'h44);
`ifdef OPFWD_STATS_EN
      checkOutput("stats stalls", bus.stat_stalls, 1);
      checkOutput("stats fwds", bus.stat_fwds, 2);
`endif

      // Register 0 ignores every bus.
      tick(); applyStimulus(1, 0, 0, 5);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd0; bus.exm_data = 32'hFF;
      bus.mwb_we = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_data = 32'hEE;
      tick(); applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("r0 out_valid", bus.out_valid, 1);
      checkOutput("r0 op_a", bus.op_a, 0);
      checkOutput("r0 op_b", bus.op_b, 0);

      // Flush while stalled drops the instruction and releases stall.
      tick(); applyStimulus(1, 7, 0, 6);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd7; bus.exm_load = 1'b1;
      @(negedge clk);
      checkOutput("flush pre stall_o", bus.stall_o, 1);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd7; bus.exm_load = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      checkOutput("flush stall_o", bus.stall_o, 0);
      checkOutput("flush bubble", bus.out_valid, 0);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd7; bus.exm_load = 1'b1;
      @(negedge clk);
      checkOutput("post flush stall_o", bus.stall_o, 0);
      checkOutput("post flush out_valid", bus.out_valid, 0);

      // Reset in the middle of a stall.
      tick(); applyStimulus(1, 2, 2, 7);
      tick(); applyStimulus(0, 0, 0, 0);
      bus.exm_we = 1'b1; bus.exm_rd = 5'd2; bus.exm_load = 1'b1;
      rst = 1'b1;
      tick(); applyStimulus(0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst stall stall_o", bus.stall_o, 0);
      checkOutput("rst stall op_a", bus.op_a, 0);
      checkOutput("rst stall out_valid", bus.out_valid, 0);

      // Randomized traffic checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         tick();
         randomCycle();
      end
      tick();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0);
      tick();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
